// File: rtl/paint_pkg.sv
// Shared types for the paint pipeline.
//   coord_t  - 8-bit canvas coordinate
//   color_t  - 3-bit color code
//   err_t    - signed 10-bit Bresenham error / delta. 10 bits hold +/-2*255.
//   state_e  - rasterizer FSM state, also exported for debug
//   clamp_coord() - saturate a coordinate to the last valid row/column
package paint_pkg;

  localparam int COORD_W = 8;
  localparam int ERR_W   = 10;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic [2:0]              color_t;
  typedef logic signed [ERR_W-1:0] err_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_STAMP = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

  function automatic coord_t clamp_coord(input coord_t v, input coord_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/stroke_rasterizer_if.sv
// Point-in / pixel-out bus of the stroke rasterizer.
//   Point channel : pt_valid, pt_ready, pt_x, pt_y, pen_down, big_brush, color
//   Write channel : wr_valid, wr_ready, wr_x, wr_y, wr_color
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. Once a source raises valid it keeps valid and its payload stable
// until the transfer completes; ready may change freely.
// master = point source / pixel store side, slave = rasterizer side.
interface stroke_rasterizer_if;
  import paint_pkg::*;

  logic   pt_valid;
  logic   pt_ready;
  coord_t pt_x;
  coord_t pt_y;
  logic   pen_down;
  logic   big_brush;
  color_t color;

  logic   wr_valid;
  logic   wr_ready;
  coord_t wr_x;
  coord_t wr_y;
  color_t wr_color;

  modport master (
    output pt_valid, pt_x, pt_y, pen_down, big_brush, color, wr_ready,
    input  pt_ready, wr_valid, wr_x, wr_y, wr_color
  );

  modport slave (
    input  pt_valid, pt_x, pt_y, pen_down, big_brush, color, wr_ready,
    output pt_ready, wr_valid, wr_x, wr_y, wr_color
  );

endinterface

// File: rtl/line_stepper.sv
// Bresenham line walker.
//   load      - capture start point (x0,y0) as current pixel, (x1,y1) as end
//   init      - derive dx, dy, step directions and initial error
//   step      - move current pixel one Bresenham step toward the end point
//   cur_x/y   - current pixel
//   done      - current pixel equals the end point
// load, init and step are mutually exclusive; the caller sequences them.
module line_stepper
  import paint_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  coord_t x0,
  input  coord_t y0,
  input  coord_t x1,
  input  coord_t y1,
  input  logic   init,
  input  logic   step,
  output coord_t cur_x,
  output coord_t cur_y,
  output logic   done
);

  coord_t cur_x_q, cur_x_d;
  coord_t cur_y_q, cur_y_d;
  coord_t end_x_q, end_x_d;
  coord_t end_y_q, end_y_d;
  err_t   dx_q, dx_d;      // |x1-x0|
  err_t   dy_q, dy_d;      // -|y1-y0|
  logic   sx_q, sx_d;      // 1: x decreases
  logic   sy_q, sy_d;      // 1: y decreases
  err_t   err_q, err_d;

  err_t diff_x, diff_y, e2, err_n;

  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    end_x_d = end_x_q;
    end_y_d = end_y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    diff_x  = $signed({2'b00, end_x_q}) - $signed({2'b00, cur_x_q});
    diff_y  = $signed({2'b00, end_y_q}) - $signed({2'b00, cur_y_q});
    e2      = err_q <<< 1;
    err_n   = err_q;

    if (load) begin
      cur_x_d = x0;
      cur_y_d = y0;
      end_x_d = x1;
      end_y_d = y1;
    end else if (init) begin
      sx_d  = diff_x[ERR_W-1];
      sy_d  = diff_y[ERR_W-1];
      dx_d  = diff_x[ERR_W-1] ? -diff_x : diff_x;
      dy_d  = diff_y[ERR_W-1] ? diff_y : -diff_y;
      err_d = (diff_x[ERR_W-1] ? -diff_x : diff_x) +
              (diff_y[ERR_W-1] ? diff_y : -diff_y);
    end else if (step) begin
      // Both tests use the error from before this step; the two updates add.
      if (e2 >= dy_q) begin
        err_n   = err_n + dy_q;
        cur_x_d = sx_q ? cur_x_q - 8'd1 : cur_x_q + 8'd1;
      end
      if (e2 <= dx_q) begin
        err_n   = err_n + dx_q;
        cur_y_d = sy_q ? cur_y_q - 8'd1 : cur_y_q + 8'd1;
      end
      err_d = err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      end_x_q <= end_x_d;
      end_y_q <= end_y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign done  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

endmodule

// File: rtl/stroke_rasterizer.sv
// Stroke rasterizer: turns a stream of pen points into pixel writes.
// A pen-down point draws a Bresenham line from the previous pen-down point
// (or a single pixel if the pen was lifted), stamping a 1x1 or 3x3 brush at
// every line pixel. A pen-up point only forgets the previous point.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   bus         - point input channel and pixel write channel (slave side)
//   busy        - high whenever the FSM is not IDLE
//   dbg_state   - current FSM state
// Parameters X_MAX / Y_MAX: last valid canvas column / row.
module stroke_rasterizer
  import paint_pkg::*;
#(
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic                clk,
  input  logic                reset,
  stroke_rasterizer_if.slave  bus,
  output logic                busy,
  output state_e              dbg_state
);

  localparam coord_t X_LIM   = coord_t'(X_MAX);
  localparam coord_t Y_LIM   = coord_t'(Y_MAX);
  localparam err_t   X_LIM_S = err_t'(X_MAX);
  localparam err_t   Y_LIM_S = err_t'(Y_MAX);

  state_e state_q, state_d;
  logic   prev_valid_q, prev_valid_d;
  coord_t prev_x_q, prev_x_d;
  coord_t prev_y_q, prev_y_d;
  logic   big_q, big_d;          // brush size latched at acceptance
  color_t color_q, color_d;      // color latched at acceptance
  logic [1:0] row_q, row_d;      // brush offset row 0..2 (= dy -1..+1)
  logic [1:0] col_q, col_d;      // brush offset column 0..2 (= dx -1..+1)

  logic   accept;
  coord_t pt_x_c, pt_y_c;
  coord_t start_x, start_y;
  logic   st_load, st_init, st_step;
  coord_t cur_x, cur_y;
  logic   line_done;

  err_t   off_x, off_y, pix_x, pix_y;
  logic   in_range, last_off, advance, wr_valid_c;

  assign accept  = (state_q == ST_IDLE) && bus.pt_valid;
  assign pt_x_c  = clamp_coord(bus.pt_x, X_LIM);
  assign pt_y_c  = clamp_coord(bus.pt_y, Y_LIM);
  assign start_x = prev_valid_q ? prev_x_q : pt_x_c;
  assign start_y = prev_valid_q ? prev_y_q : pt_y_c;

  line_stepper u_line_stepper (
    .clk   (clk),
    .reset (reset),
    .load  (st_load),
    .x0    (start_x),
    .y0    (start_y),
    .x1    (pt_x_c),
    .y1    (pt_y_c),
    .init  (st_init),
    .step  (st_step),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .done  (line_done)
  );

  // Brush pixel for the current offset; signed so off-canvas offsets
  // (-1 or past the edge) are detected and skipped instead of wrapping.
  always_comb begin
    off_x      = big_q ? ($signed({8'b0, col_q}) - 10'sd1) : '0;
    off_y      = big_q ? ($signed({8'b0, row_q}) - 10'sd1) : '0;
    pix_x      = $signed({2'b00, cur_x}) + off_x;
    pix_y      = $signed({2'b00, cur_y}) + off_y;
    in_range   = !pix_x[ERR_W-1] && (pix_x <= X_LIM_S) &&
                 !pix_y[ERR_W-1] && (pix_y <= Y_LIM_S);
    last_off   = !big_q || ((row_q == 2'd2) && (col_q == 2'd2));
    wr_valid_c = (state_q == ST_STAMP) && in_range;
    // A skipped offset consumes its cycle without a handshake.
    advance    = (state_q == ST_STAMP) && (!in_range || bus.wr_ready);
  end

  always_comb begin
    state_d      = state_q;
    prev_valid_d = prev_valid_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    big_d        = big_q;
    color_d      = color_q;
    row_d        = row_q;
    col_d        = col_q;
    st_load      = 1'b0;
    st_init      = 1'b0;
    st_step      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.pen_down) begin
            st_load      = 1'b1;
            prev_valid_d = 1'b1;
            prev_x_d     = pt_x_c;
            prev_y_d     = pt_y_c;
            big_d        = bus.big_brush;
            color_d      = bus.color;
            state_d      = ST_INIT;
          end else begin
            prev_valid_d = 1'b0;
          end
        end
      end
      ST_INIT: begin
        st_init = 1'b1;
        row_d   = 2'd0;
        col_d   = 2'd0;
        state_d = ST_STAMP;
      end
      ST_STAMP: begin
        if (advance) begin
          if (last_off) begin
            row_d   = 2'd0;
            col_d   = 2'd0;
            state_d = line_done ? ST_IDLE : ST_STEP;
          end else if (col_q == 2'd2) begin
            col_d = 2'd0;
            row_d = row_q + 2'd1;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      ST_STEP: begin
        st_step = 1'b1;
        state_d = ST_STAMP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_valid_q <= 1'b0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      big_q        <= 1'b0;
      color_q      <= '0;
      row_q        <= 2'd0;
      col_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      big_q        <= big_d;
      color_q      <= color_d;
      row_q        <= row_d;
      col_q        <= col_d;
    end
  end

  // Write payload derives only from registers, so it stays put while stalled.
  assign bus.pt_ready = (state_q == ST_IDLE);
  assign bus.wr_valid = wr_valid_c;
  assign bus.wr_x     = wr_valid_c ? pix_x[COORD_W-1:0] : '0;
  assign bus.wr_y     = wr_valid_c ? pix_y[COORD_W-1:0] : '0;
  assign bus.wr_color = wr_valid_c ? color_q : '0;
  assign busy         = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_stroke_rasterizer.sv
module tb_stroke_rasterizer;
  import paint_pkg::*;

  localparam int X_LIM = 159;
  localparam int Y_LIM = 119;
  localparam int W     = 19;
  localparam int IDLE_BOUND = 20000;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  logic   busy;
  state_e dbg_state;

  always #5 clk = ~clk;

  stroke_rasterizer_if bus();

  stroke_rasterizer #(.X_MAX(X_LIM), .Y_MAX(Y_LIM)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int wr_count     = 0;
  int stamp_cycles = 0;
  logic [W-1:0] last_wr = '0;
  bit rand_ready = 1'b0;
  bit stall_req  = 1'b0;
  bit hold_pending = 1'b0;
  logic [W-1:0] hold_data = '0;

  // reference model state
  bit m_prev_valid = 1'b0;
  int m_px = 0;
  int m_py = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic int model_stamp(int x, int y, bit big, int c);
    int n = 0;
    if (!big) begin
      exp_q.push_back({8'(x), 8'(y), 3'(c)});
      return 1;
    end
    for (int oy = -1; oy <= 1; oy++)
      for (int ox = -1; ox <= 1; ox++)
        if (x + ox >= 0 && x + ox <= X_LIM && y + oy >= 0 && y + oy <= Y_LIM) begin
          exp_q.push_back({8'(x + ox), 8'(y + oy), 3'(c)});
          n++;
        end
    return n;
  endfunction

  function automatic int model_point(int x_in, int y_in, bit pen, bit big, int c);
    int x1, y1, x, y, dx, dy, sx, sy, err, e2, n;
    x1 = (x_in > X_LIM) ? X_LIM : x_in;
    y1 = (y_in > Y_LIM) ? Y_LIM : y_in;
    if (!pen) begin
      m_prev_valid = 1'b0;
      return 0;
    end
    x = m_prev_valid ? m_px : x1;
    y = m_prev_valid ? m_py : y1;
    m_prev_valid = 1'b1;
    m_px = x1;
    m_py = y1;
    dx  = (x1 > x) ? x1 - x : x - x1;
    dy  = (y1 > y) ? y - y1 : y1 - y;
    sx  = (x1 >= x) ? 1 : -1;
    sy  = (y1 >= y) ? 1 : -1;
    err = dx + dy;
    n   = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      n += model_stamp(x, y, big, c);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return n;
  endfunction

  // ---------------- wr_ready driver ----------------
  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : !stall_req;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (dbg_state == ST_STAMP) stamp_cycles++;
      if (hold_pending) begin
        check("hold_valid", 32'(bus.wr_valid), 32'd1);
        check("hold_data", 32'({bus.wr_x, bus.wr_y, bus.wr_color}), 32'(hold_data));
      end
      hold_pending = bus.wr_valid && !bus.wr_ready;
      hold_data    = {bus.wr_x, bus.wr_y, bus.wr_color};
      if (bus.wr_valid && bus.wr_ready) begin
        wr_count++;
        last_wr = {bus.wr_x, bus.wr_y, bus.wr_color};
        check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("wr_pix", 32'(last_wr), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_point(input int x, input int y, input bit pen, input bit big,
                            input int c, output int n_exp);
    int waitc = 0;
    n_exp = 0;
    @(negedge clk);
    bus.pt_x      = 8'(x);
    bus.pt_y      = 8'(y);
    bus.pen_down  = pen;
    bus.big_brush = big;
    bus.color     = 3'(c);
    bus.pt_valid  = 1'b1;
    while (!bus.pt_ready && waitc < IDLE_BOUND) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= IDLE_BOUND) begin
      check("pt_ready_timeout", 32'(waitc), 32'd0);
      bus.pt_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n_exp = model_point(x, y, pen, big, c);
    #1;
    bus.pt_valid  = 1'b0;
    // Scramble the point inputs; the line in flight must not notice.
    bus.big_brush = 1'($urandom_range(0, 1));
    bus.color     = 3'($urandom_range(0, 7));
    bus.pt_x      = 8'($urandom);
    bus.pt_y      = 8'($urandom);
  endtask

  task automatic wait_idle();
    int waitc = 0;
    @(negedge clk);
    while (busy && waitc < IDLE_BOUND) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= IDLE_BOUND) check("idle_timeout", 32'(waitc), 32'd0);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic draw(input int x, input int y, input bit pen, input bit big,
                      input int c, output int n_wr);
    int n_exp;
    int base;
    base = wr_count;
    send_point(x, y, pen, big, c, n_exp);
    wait_idle();
    n_wr = wr_count - base;
    check("wr_count", 32'(n_wr), 32'(n_exp));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, n_exp, base, sbase;
    reset = 1'b1;
    bus.pt_valid  = 1'b0;
    bus.pt_x      = '0;
    bus.pt_y      = '0;
    bus.pen_down  = 1'b0;
    bus.big_brush = 1'b0;
    bus.color     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pt_ready", 32'(bus.pt_ready), 32'd1);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_wr_data",  32'({bus.wr_x, bus.wr_y, bus.wr_color}), 32'd0);
    check("rst_state",    32'(dbg_state),    32'(ST_IDLE));
    @(posedge clk);
    #1 reset = 1'b0;

    // single pixel, latency from acceptance
    base = wr_count;
    send_point(10, 10, 1'b1, 1'b0, 5, n_exp);
    @(negedge clk);
    check("lat_init_valid", 32'(bus.wr_valid), 32'd0);
    check("lat_init_busy",  32'(busy),         32'd1);
    @(negedge clk);
    check("lat_stamp_valid", 32'(bus.wr_valid), 32'd1);
    check("lat_stamp_xy",    32'({bus.wr_x, bus.wr_y}), 32'({8'd10, 8'd10}));
    wait_idle();
    check("single_count", 32'(wr_count - base), 32'd1);

    // short line (0,0) -> (5,2)
    draw(0, 0, 1'b0, 1'b0, 0, n);
    draw(0, 0, 1'b1, 1'b0, 1, n);
    draw(5, 2, 1'b1, 1'b0, 1, n);
    check("line52_count", 32'(n), 32'd6);
    check("line52_last", 32'(last_wr), 32'({8'd5, 8'd2, 3'd1}));

    // big brush at the corner
    draw(0, 0, 1'b0, 1'b0, 0, n);
    sbase = stamp_cycles;
    draw(0, 0, 1'b1, 1'b1, 7, n);
    check("corner_count", 32'(n), 32'd4);
    check("corner_stamps", 32'(stamp_cycles - sbase), 32'd9);

    // back-pressure mid-line
    draw(0, 0, 1'b0, 1'b0, 0, n);
    draw(0, 0, 1'b1, 1'b0, 2, n);
    base = wr_count;
    send_point(30, 10, 1'b1, 1'b0, 2, n_exp);
    repeat (4) @(posedge clk);
    #1 stall_req = 1'b1;
    repeat (5) @(posedge clk);
    #1 stall_req = 1'b0;
    wait_idle();
    check("stall_count", 32'(wr_count - base), 32'd31);

    // clamping and pen-up
    draw(0, 0, 1'b0, 1'b0, 0, n);
    draw(200, 130, 1'b1, 1'b0, 3, n);
    check("clamp_count", 32'(n), 32'd1);
    check("clamp_pix", 32'(last_wr), 32'({8'd159, 8'd119, 3'd3}));
    draw(10, 10, 1'b0, 1'b0, 0, n);
    check("penup_count", 32'(n), 32'd0);
    draw(0, 0, 1'b1, 1'b0, 3, n);
    check("after_penup_count", 32'(n), 32'd1);

    // reset in the middle of a long line
    draw(0, 0, 1'b0, 1'b0, 0, n);
    draw(0, 0, 1'b1, 1'b0, 6, n);
    base = wr_count;
    send_point(100, 40, 1'b1, 1'b0, 6, n_exp);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    m_prev_valid = 1'b0;
    @(negedge clk);
    check("abort_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("abort_busy",     32'(busy),         32'd0);
    check("abort_pt_ready", 32'(bus.pt_ready), 32'd1);
    check("abort_partial",  32'((wr_count - base) < 101), 32'd1);
    base = wr_count;
    repeat (10) @(negedge clk);
    check("abort_quiet", 32'(wr_count - base), 32'd0);
    draw(50, 50, 1'b1, 1'b0, 4, n);
    check("abort_prev_cleared", 32'(n), 32'd1);

    // randomized strokes with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      draw($urandom_range(0, 220), $urandom_range(0, 150),
           1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 3) == 0),
           $urandom_range(0, 7), n);
    end
    rand_ready = 1'b0;

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
